// File: rtl/store_write_unit.sv
// store_write_unit: store path of the MIPS_32 data memory.
//
// Takes SB/SH/SW requests from the MEM stage and places the register data on the
// right byte lanes. Legal stores are queued in a DEPTH-entry FIFO. Illegal ones
// (misaligned half or word, or size 11) are dropped and raise a one-cycle st_err.
// The queue drains to data memory over a req/ack handshake.
//
// Optional feature macro: STORE_FWD_EN. When it is defined, ld_hit compares every
// valid entry against ld_addr. When it is not defined, ld_hit is tied to 0.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   st_valid/st_ready     store request handshake (st_ready = !full)
//   st_addr/st_data       byte address; LSB-justified register value
//   st_size               00 byte, 01 half, 10 word, 11 illegal
//   st_err                one-cycle pulse after a rejected store
//   mem_req/mem_ack       write handshake to data memory
//   mem_addr/mem_wdata    word address and lane-aligned data of the head entry
//   mem_be                byte enables, bit i covers wdata[8i+7:8i]
//   count, empty          FIFO occupancy; empty also needs no request outstanding
//   ld_addr, ld_hit       load address, and overlap with a pending store
module store_write_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_size,
  output logic             st_err,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit
);

  localparam int unsigned PtrW = CNT_W - 1;
  localparam logic [CNT_W-1:0] FullCount = CNT_W'(DEPTH);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;

  logic [29:0]       fifo_addr_q [DEPTH];
  logic [31:0]       fifo_data_q [DEPTH];
  logic [3:0]        fifo_be_q   [DEPTH];

  // Lane alignment and legality of the incoming store.
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_legal;

  always_comb begin
    al_wdata = '0;
    al_be    = '0;
    al_legal = 1'b0;
    unique case (st_size)
      2'b00: begin
        al_legal = 1'b1;
        al_be    = 4'b0001 << st_addr[1:0];
        al_wdata = {24'b0, st_data[7:0]} << {st_addr[1:0], 3'b000};
      end
      2'b01: begin
        al_legal = ~st_addr[0];
        al_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        al_wdata = {16'b0, st_data[15:0]} << {st_addr[1], 4'b0000};
      end
      2'b10: begin
        al_legal = (st_addr[1:0] == 2'b00);
        al_be    = 4'b1111;
        al_wdata = st_data;
      end
      default: al_legal = 1'b0;
    endcase
  end

  logic push, pop;
  logic load;
  logic [PtrW-1:0] load_idx;

  // A full FIFO refuses new stores, even in a cycle where an ack frees a slot.
  assign st_ready = (count_q != FullCount);
  assign push     = st_valid && st_ready && al_legal;
  assign err_d    = st_valid && st_ready && !al_legal;
  // The in-flight entry stays in the FIFO until it is acked.
  assign pop      = (state_q == StReq) && mem_ack;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  // Drain FSM. The head is copied into the output registers; on an ack the next
  // entry is loaded straight away, so back-to-back writes have no bubble.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_idx = rd_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          load    = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ack) begin
          if (count_q > CNT_W'(1)) begin
            load     = 1'b1;
            load_idx = rd_ptr_q + PtrW'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (load) begin
      mem_addr_d  = {fifo_addr_q[load_idx], 2'b00};
      mem_wdata_d = fifo_data_q[load_idx];
      mem_be_d    = fifo_be_q[load_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset because occupancy is tracked by count_q and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= st_addr[31:2];
      fifo_data_q[wr_ptr_q] <= al_wdata;
      fifo_be_q[wr_ptr_q]   <= al_be;
    end
  end

  assign mem_req   = (state_q == StReq);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign st_err    = err_q;
  assign count     = count_q;
  assign empty     = (count_q == '0) && (state_q != StReq);

`ifdef STORE_FWD_EN
  // An entry is valid when its distance from the read pointer is below count.
  logic [PtrW-1:0] offset;
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];

  always_comb begin
    ld_hit = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PtrW'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) && (fifo_addr_q[i] == ld_addr[31:2]) &&
          (|fifo_be_q[i])) begin
        ld_hit = 1'b1;
      end
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hit = 1'b0;
`endif

endmodule
